trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl_pkg.sv | 55 +++++
 rtl/trap_ctrl_int_select.sv | 42 ++++
 rtl/trap_ctrl.sv | 164 ++++++++++++++++
 tb/tb_trap_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// CSRStruct: shared CSR snapshot type, trap FSM states, privilege and interrupt codes (rev 1.0).
`default_nettype none

package CSRStruct;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } trap_state_e;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  localparam logic [5:0] INT_SSI = 6'd1;
  localparam logic [5:0] INT_MSI = 6'd3;
  localparam logic [5:0] INT_STI = 6'd5;
  localparam logic [5:0] INT_MTI = 6'd7;
  localparam logic [5:0] INT_SEI = 6'd9;
  localparam logic [5:0] INT_MEI = 6'd11;

  // Index 5 is the highest priority, index 0 the lowest.
  localparam logic [5:0][5:0] INT_PRIO = {INT_MEI, INT_MSI, INT_MTI, INT_SEI, INT_SSI, INT_STI};

  localparam int MSTATUS_SIE = 1;
  localparam int MSTATUS_MIE = 3;
  localparam int MSTATUS_SPP = 8;
  localparam int MSTATUS_MPP = 11;

  typedef struct packed {
    logic [63:0] mstatus;
    logic [63:0] sstatus;
    logic [63:0] mie;
    logic [63:0] mip;
    logic [63:0] mideleg;
    logic [63:0] medeleg;
    logic [63:0] mtvec;
    logic [63:0] stvec;
    logic [63:0] mepc;
    logic [63:0] sepc;
  } CSRPack;

  function automatic logic [63:0] trap_vector(input logic [63:0] tvec, input logic is_int,
                                              input logic [5:0] code);
    logic [63:0] base;
    base = {tvec[63:2], 2'b00};
    if (is_int && (tvec[1:0] == 2'b01)) return base + {56'd0, code, 2'b00};
    return base;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trap_ctrl_int_select.sv
// int_select: picks the highest-priority pending, enabled interrupt and its target mode (rev 1.0).
`default_nettype none

module int_select
  import CSRStruct::*;
(
  input  logic [1:0] cur_priv_i,
  input  CSRPack     csr_i,
  output logic       int_valid_o,
  output logic [5:0] int_code_o,
  output logic       int_to_s_o
);

  logic        m_ok;
  logic        s_ok;
  logic [63:0] en;
  logic        unused_sink;

  // Delegated interrupts are only reachable below M; s_ok is therefore 0 in M-mode.
  assign m_ok = (cur_priv_i != PRIV_M) || csr_i.mstatus[MSTATUS_MIE];
  assign s_ok = (cur_priv_i == PRIV_U) ||
                ((cur_priv_i == PRIV_S) && csr_i.sstatus[MSTATUS_SIE]);
  assign en   = csr_i.mip & csr_i.mie &
                ((csr_i.mideleg & {64{s_ok}}) | (~csr_i.mideleg & {64{m_ok}}));

  always_comb begin
    int_valid_o = 1'b0;
    int_code_o  = '0;
    for (int i = 0; i < 6; i++) begin
      if (en[INT_PRIO[i]]) begin
        int_valid_o = 1'b1;
        int_code_o  = INT_PRIO[i];
      end
    end
  end

  assign int_to_s_o  = csr_i.mideleg[int_code_o];
  assign unused_sink = ^{csr_i, en};

endmodule

`default_nettype wire

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap/xRET sequencer (IDLE->FLUSH->COMMIT->REDIRECT), registered outputs (rev 1.0).
// Optional TRAP_COSIM_EN adds cosim_* outputs carrying the committed trap values.
`default_nettype none

module trap_ctrl
  import CSRStruct::*;
#(
  parameter logic [1:0] RESET_PRIV = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [63:0] exc_cause,
  input  logic [63:0] exc_pc,
  input  logic [63:0] exc_tval,
  input  logic        ret_valid,
  input  logic        ret_is_m,
  input  logic        int_ok,
  input  CSRPack      csr_in,
  output logic        flush,
  output logic        trap_commit,
  output logic        trap_to_s,
  output logic [63:0] trap_cause,
  output logic [63:0] trap_epc,
  output logic [63:0] trap_tval,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic [1:0]  cur_priv,
  output logic        busy
`ifdef TRAP_COSIM_EN
  ,
  output logic        cosim_valid,
  output logic [63:0] cosim_epc,
  output logic [63:0] cosim_cause,
  output logic [63:0] cosim_tval
`endif
);

  trap_state_e state_q;
  logic        flush_q, commit_q, to_s_q, redir_q, busy_q;
  logic [63:0] cause_q, epc_q, tval_q, redir_pc_q, target_q;
  logic [1:0]  priv_q;

  logic        int_valid, int_to_s;
  logic [5:0]  int_code;
  logic        take_trap_d, take_int_d, take_ret_d, to_s_d;
  logic [63:0] target_d, ret_pc_d;
  logic [1:0]  ret_priv_d;

  int_select u_int_select (
    .cur_priv_i  (priv_q),
    .csr_i       (csr_in),
    .int_valid_o (int_valid),
    .int_code_o  (int_code),
    .int_to_s_o  (int_to_s)
  );

  always_comb begin
    take_int_d  = !exc_valid && int_ok && int_valid;
    take_trap_d = exc_valid || take_int_d;
    take_ret_d  = !take_trap_d && ret_valid;
    to_s_d      = exc_valid ? ((priv_q <= PRIV_S) && csr_in.medeleg[exc_cause[5:0]]) : int_to_s;
    target_d    = trap_vector(to_s_d ? csr_in.stvec : csr_in.mtvec, take_int_d, int_code);
    ret_pc_d    = ret_is_m ? csr_in.mepc : csr_in.sepc;
    ret_priv_d  = ret_is_m ? csr_in.mstatus[MSTATUS_MPP +: 2]
                           : (csr_in.sstatus[MSTATUS_SPP] ? PRIV_S : PRIV_U);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      flush_q    <= 1'b0;
      commit_q   <= 1'b0;
      to_s_q     <= 1'b0;
      redir_q    <= 1'b0;
      busy_q     <= 1'b0;
      cause_q    <= '0;
      epc_q      <= '0;
      tval_q     <= '0;
      redir_pc_q <= '0;
      target_q   <= '0;
      priv_q     <= RESET_PRIV;
    end else begin
      flush_q  <= 1'b0;
      commit_q <= 1'b0;
      redir_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (take_trap_d) begin
            state_q  <= ST_FLUSH;
            flush_q  <= 1'b1;
            busy_q   <= 1'b1;
            to_s_q   <= to_s_d;
            cause_q  <= exc_valid ? exc_cause : {1'b1, 57'd0, int_code};
            epc_q    <= exc_pc;
            tval_q   <= exc_valid ? exc_tval : 64'd0;
            target_q <= target_d;
          end else if (take_ret_d) begin
            state_q    <= ST_REDIRECT;
            flush_q    <= 1'b1;
            redir_q    <= 1'b1;
            busy_q     <= 1'b1;
            redir_pc_q <= ret_pc_d;
            priv_q     <= ret_priv_d;
          end
        end
        ST_FLUSH: begin
          state_q  <= ST_COMMIT;
          commit_q <= 1'b1;
          priv_q   <= to_s_q ? PRIV_S : PRIV_M;
        end
        ST_COMMIT: begin
          state_q    <= ST_REDIRECT;
          redir_q    <= 1'b1;
          redir_pc_q <= target_q;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign flush          = flush_q;
  assign trap_commit    = commit_q;
  assign trap_to_s      = to_s_q;
  assign trap_cause     = cause_q;
  assign trap_epc       = epc_q;
  assign trap_tval      = tval_q;
  assign redirect_valid = redir_q;
  assign redirect_pc    = redir_pc_q;
  assign cur_priv       = priv_q;
  assign busy           = busy_q;

`ifdef TRAP_COSIM_EN
  logic        cosim_valid_q;
  logic [63:0] cosim_epc_q, cosim_cause_q, cosim_tval_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cosim_valid_q <= 1'b0;
      cosim_epc_q   <= '0;
      cosim_cause_q <= '0;
      cosim_tval_q  <= '0;
    end else begin
      cosim_valid_q <= (state_q == ST_FLUSH);
      if (state_q == ST_FLUSH) begin
        cosim_epc_q   <= epc_q;
        cosim_cause_q <= cause_q;
        cosim_tval_q  <= tval_q;
      end
    end
  end

  assign cosim_valid = cosim_valid_q;
  assign cosim_epc   = cosim_epc_q;
  assign cosim_cause = cosim_cause_q;
  assign cosim_tval  = cosim_tval_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed vectors with hand-computed expectations for trap_ctrl (rev 1.0).
`default_nettype none

module tb_trap_ctrl;
  import CSRStruct::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid, ret_valid, ret_is_m, int_ok;
  logic [63:0] exc_cause, exc_pc, exc_tval;
  CSRPack      csr;
  logic        flush, trap_commit, trap_to_s, redirect_valid, busy;
  logic [63:0] trap_cause, trap_epc, trap_tval, redirect_pc;
  logic [1:0]  cur_priv;

  int n_tests = 0;
  int n_fail  = 0;

  trap_ctrl #(.RESET_PRIV(2'b11)) dut (
    .clk            (clk),
    .rst            (rst),
    .exc_valid      (exc_valid),
    .exc_cause      (exc_cause),
    .exc_pc         (exc_pc),
    .exc_tval       (exc_tval),
    .ret_valid      (ret_valid),
    .ret_is_m       (ret_is_m),
    .int_ok         (int_ok),
    .csr_in         (csr),
    .flush          (flush),
    .trap_commit    (trap_commit),
    .trap_to_s      (trap_to_s),
    .trap_cause     (trap_cause),
    .trap_epc       (trap_epc),
    .trap_tval      (trap_tval),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .cur_priv       (cur_priv),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int redirects;

  initial begin
    rst = 1'b1; exc_valid = 0; ret_valid = 0; ret_is_m = 0; int_ok = 0;
    exc_cause = '0; exc_pc = '0; exc_tval = '0; csr = '0;
    step(); step();
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_priv", {62'd0, cur_priv}, 64'd3);
    check_eq("rst_flush", {63'd0, flush}, 64'd0);
    check_eq("rst_rpc", redirect_pc, 64'd0);
    rst = 1'b0;
    step();

    // mret to U-mode
    csr.mepc = 64'h1000;
    ret_valid = 1; ret_is_m = 1;
    step();
    ret_valid = 0;
    check_eq("mret_rv", {63'd0, redirect_valid}, 64'd1);
    check_eq("mret_rpc", redirect_pc, 64'h1000);
    check_eq("mret_flush", {63'd0, flush}, 64'd1);
    check_eq("mret_priv", {62'd0, cur_priv}, 64'd0);
    check_eq("mret_commit", {63'd0, trap_commit}, 64'd0);
    step();
    check_eq("mret_idle", {63'd0, busy}, 64'd0);
    check_eq("mret_commit2", {63'd0, trap_commit}, 64'd0);

    // U-mode ecall delegated to S
    csr.medeleg[8] = 1'b1; csr.stvec = 64'h8020_0000;
    exc_valid = 1; exc_cause = 64'd8; exc_pc = 64'h2000; exc_tval = 64'd0;
    step();
    exc_valid = 0;
    check_eq("deleg_flush", {63'd0, flush}, 64'd1);
    check_eq("deleg_busy", {63'd0, busy}, 64'd1);
    step();
    check_eq("deleg_commit", {63'd0, trap_commit}, 64'd1);
    check_eq("deleg_tos", {63'd0, trap_to_s}, 64'd1);
    check_eq("deleg_priv", {62'd0, cur_priv}, 64'd1);
    check_eq("deleg_cause", trap_cause, 64'd8);
    check_eq("deleg_epc", trap_epc, 64'h2000);
    step();
    check_eq("deleg_rv", {63'd0, redirect_valid}, 64'd1);
    check_eq("deleg_rpc", redirect_pc, 64'h8020_0000);
    step();
    check_eq("deleg_idle", {63'd0, busy}, 64'd0);

    // S-mode exception not delegated -> M; extra exc_valid while busy ignored
    csr.mtvec = 64'h8000_0000;
    exc_valid = 1; exc_cause = 64'd2; exc_pc = 64'h2100; exc_tval = 64'hdead;
    step();
    exc_cause = 64'd5; exc_tval = 64'hbeef;
    step();
    check_eq("m_tos", {63'd0, trap_to_s}, 64'd0);
    check_eq("m_priv", {62'd0, cur_priv}, 64'd3);
    check_eq("m_cause", trap_cause, 64'd2);
    check_eq("m_tval", trap_tval, 64'hdead);
    step();
    exc_valid = 0;
    check_eq("m_rpc", redirect_pc, 64'h8000_0000);
    redirects = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (redirect_valid) redirects++;
    end
    check_eq("busy_ignored", 64'(redirects), 64'd0);

    // MTI with MIE=0 must not trap, then with MIE=1 it does
    csr.mip[7] = 1'b1; csr.mie[7] = 1'b1; int_ok = 1; exc_pc = 64'h3000;
    step(); step(); step();
    check_eq("mie0_busy", {63'd0, busy}, 64'd0);
    csr.mstatus[MSTATUS_MIE] = 1'b1;
    step();
    int_ok = 0;
    check_eq("mti_flush", {63'd0, flush}, 64'd1);
    step();
    check_eq("mti_cause", trap_cause, 64'h8000_0000_0000_0007);
    check_eq("mti_tval", trap_tval, 64'd0);
    check_eq("mti_epc", trap_epc, 64'h3000);
    step();
    check_eq("mti_rpc", redirect_pc, 64'h8000_0000);
    step();

    // Vectored mtvec, MEI beats MTI
    csr.mtvec = 64'h8000_0101; csr.mip[11] = 1'b1; csr.mie[11] = 1'b1; int_ok = 1;
    step();
    int_ok = 0;
    step();
    check_eq("mei_cause", trap_cause, 64'h8000_0000_0000_000B);
    step();
    check_eq("mei_rpc", redirect_pc, 64'h8000_012C);
    step();
    csr.mip = '0; csr.mie = '0; csr.mtvec = 64'h8000_0000;

    // Exception wins over simultaneous mret; reset in COMMIT
    exc_valid = 1; ret_valid = 1; ret_is_m = 1; exc_cause = 64'd2; exc_pc = 64'h5000;
    step();
    exc_valid = 0; ret_valid = 0;
    check_eq("pri_flush", {63'd0, flush}, 64'd1);
    check_eq("pri_rv", {63'd0, redirect_valid}, 64'd0);
    step();
    check_eq("pri_commit", {63'd0, trap_commit}, 64'd1);
    rst = 1'b1;
    step();
    check_eq("mid_rst_busy", {63'd0, busy}, 64'd0);
    check_eq("mid_rst_commit", {63'd0, trap_commit}, 64'd0);
    check_eq("mid_rst_cause", trap_cause, 64'd0);
    check_eq("mid_rst_priv", {62'd0, cur_priv}, 64'd3);
    rst = 1'b0;
    step();
    check_eq("post_rst_rv", {63'd0, redirect_valid}, 64'd0);

    // sret with SPP=1 returns to S at sepc
    csr.sstatus[MSTATUS_SPP] = 1'b1; csr.sepc = 64'h4000;
    ret_valid = 1; ret_is_m = 0;
    step();
    ret_valid = 0;
    check_eq("sret_rpc", redirect_pc, 64'h4000);
    check_eq("sret_priv", {62'd0, cur_priv}, 64'd1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
